program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_pkg.sv | 23 ++
 rtl/ps_return_stack.sv | 61 ++++++
 rtl/program_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_program_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer: address widths, return-stack
// sizing, FSM state encoding and the jump-target helper.
// Optional feature macro: PS_RETURN_STACK_EN (return stack, see program_sequencer.sv).
package program_sequencer_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    PS_RUN    = 2'd0,
    PS_HALTED = 2'd1,
    PS_STEP   = 2'd2
  } ps_state_t;

  // Jump/call targets are page-aligned: the nibble selects one of 16 pages.
  function automatic logic [ADDR_W-1:0] jump_target(input logic [NIBBLE_W-1:0] nibble);
    return {nibble, (ADDR_W - NIBBLE_W)'(0)};
  endfunction

endpackage

// File: rtl/ps_return_stack.sv
// Return-address stack for the program sequencer, RAS_DEPTH entries.
// Circular storage: a push when full overwrites the oldest entry (reported on
// overflow); a pop when empty leaves the stack untouched.
// Compiled only when PS_RETURN_STACK_EN is defined.
// Ports:
//   clk, reset_n  clock, async active-low reset (stack empties)
//   push, pop     push wins if both are asserted
//   push_data     return address to store
//   top           current top-of-stack entry (valid when !empty)
//   empty, full   occupancy flags
//   overflow      push while full (oldest entry being dropped this cycle)
`ifdef PS_RETURN_STACK_EN
module ps_return_stack
  import program_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  logic [ADDR_W-1:0]    r_mem [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] r_top_idx;
  logic [RAS_CNT_W-1:0] r_count;
  logic [RAS_PTR_W-1:0] w_push_idx;

  // Pointer arithmetic wraps modulo RAS_DEPTH (a power of two), which is what
  // makes a push on a full stack land on the oldest entry.
  assign w_push_idx = r_top_idx + RAS_PTR_W'(1);
  assign empty      = (r_count == '0);
  assign full       = (r_count == RAS_CNT_W'(RAS_DEPTH));
  assign overflow   = push && full;
  assign top        = r_mem[r_top_idx];

  // Storage, top pointer and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_top_idx <= '0;
      r_count   <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_mem[RAS_PTR_W'(i)] <= '0;
      end
    end else if (push) begin
      r_mem[w_push_idx] <= push_data;
      r_top_idx         <= w_push_idx;
      if (!full) begin
        r_count <= r_count + RAS_CNT_W'(1);
      end
    end else if (pop && !empty) begin
      r_top_idx <= r_top_idx - RAS_PTR_W'(1);
      r_count   <= r_count - RAS_CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/program_sequencer.sv
// Program sequencer: program counter, jump/call/return address selection and a
// run/halt/single-step debug FSM.
// Optional feature macro: PS_RETURN_STACK_EN enables call/ret through a
// RAS_DEPTH-entry return stack; without it call/ret are ignored and stack_err
// is 0.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   jmp, jmp_nz, ir_nibble  jump controls and page target from the decoder
//   dont_jmp                ALU zero flag, suppresses jmp_nz
//   call, ret               subroutine call / return
//   halt_req, step_req      debug halt (level) and single-step (pulse)
//   pm_addr                 program memory address (combinational)
//   pc, from_PS             registered program counter and its debug tap
//   exec_en                 instruction in ir may execute this cycle
//   halted, step_ack        debug status
//   stack_err               sticky return-stack overflow/underflow
module program_sequencer
  import program_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                jmp,
  input  logic                jmp_nz,
  input  logic [NIBBLE_W-1:0] ir_nibble,
  input  logic                dont_jmp,
  input  logic                call,
  input  logic                ret,
  input  logic                halt_req,
  input  logic                step_req,
  output logic [ADDR_W-1:0]   pm_addr,
  output logic [ADDR_W-1:0]   pc,
  output logic                exec_en,
  output logic                halted,
  output logic                step_ack,
  output logic                stack_err,
  output logic [ADDR_W-1:0]   from_PS
);

  ps_state_t         r_state;
  ps_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pm_addr;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;
  logic              r_exec_en;
  logic              r_halted;
  logic              r_step_ack;
  logic              w_exec_en_nxt;
  logic              w_halted_nxt;
  logic              w_step_ack_nxt;
  logic              w_jmp_take;
  logic              w_unused;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_target   = jump_target(ir_nibble);
  assign w_jmp_take = jmp || (jmp_nz && !dont_jmp);

`ifdef PS_RETURN_STACK_EN
  logic              w_push;
  logic              w_pop;
  logic              w_underflow;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_full;
  logic              w_ras_overflow;
  logic              r_stack_err;

  ps_return_stack u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (r_pc),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full),
    .overflow  (w_ras_overflow)
  );

  // Sticky stack fault, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stack_err <= 1'b0;
    end else if (w_ras_overflow || w_underflow) begin
      r_stack_err <= 1'b1;
    end
  end

  assign stack_err = r_stack_err;
  // Overflow is reported by the stack itself; the full flag is not needed here.
  assign w_unused  = w_ras_full;
`else
  assign stack_err = 1'b0;
  assign w_unused  = ^{call, ret};
`endif

  // Next fetch address. r_pc already points one past the executing
  // instruction, so it is both the sequential successor base and the return
  // address pushed by a call.
  always_comb begin
    w_pm_addr = r_pc;
`ifdef PS_RETURN_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_underflow = 1'b0;
`endif
    if (r_exec_en) begin
      if (w_jmp_take) begin
        w_pm_addr = w_target;
`ifdef PS_RETURN_STACK_EN
      end else if (call) begin
        w_pm_addr = w_target;
        w_push    = 1'b1;
      end else if (ret) begin
        if (w_ras_empty) begin
          w_pm_addr   = w_pc_inc;
          w_underflow = 1'b1;
        end else begin
          w_pm_addr = w_ras_top;
          w_pop     = 1'b1;
        end
`endif
      end else begin
        w_pm_addr = w_pc_inc;
      end
    end
  end

  // Debug FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= PS_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Debug FSM next state; status outputs are derived from the next state so
  // they line up with the state once registered.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PS_RUN: begin
        if (halt_req) begin
          w_state_nxt = PS_HALTED;
        end
      end
      PS_HALTED: begin
        if (!halt_req) begin
          w_state_nxt = PS_RUN;
        end else if (step_req) begin
          w_state_nxt = PS_STEP;
        end
      end
      PS_STEP: begin
        w_state_nxt = halt_req ? PS_HALTED : PS_RUN;
      end
      default: begin
        w_state_nxt = PS_RUN;
      end
    endcase
    w_exec_en_nxt  = (w_state_nxt != PS_HALTED);
    w_halted_nxt   = (w_state_nxt == PS_HALTED);
    w_step_ack_nxt = (w_state_nxt == PS_STEP);
  end

  // Program counter and registered status. exec_en stays 0 until the first
  // edge after reset so that edge fetches address 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= '0;
      r_exec_en  <= 1'b0;
      r_halted   <= 1'b0;
      r_step_ack <= 1'b0;
    end else begin
      r_pc       <= w_pm_addr;
      r_exec_en  <= w_exec_en_nxt;
      r_halted   <= w_halted_nxt;
      r_step_ack <= w_step_ack_nxt;
    end
  end

  assign pm_addr  = w_pm_addr;
  assign pc       = r_pc;
  assign from_PS  = r_pc;
  assign exec_en  = r_exec_en;
  assign halted   = r_halted;
  assign step_ack = r_step_ack;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer. Each driven cycle pushes its
// expected outputs to a scoreboard queue; a negedge monitor pops and compares.
// Stack expectations follow PS_RETURN_STACK_EN.
module tb_program_sequencer;

`ifdef PS_RETURN_STACK_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       jmp, jmp_nz, dont_jmp, call, ret, halt_req, step_req;
  logic [3:0] ir_nibble;
  logic [7:0] pm_addr, pc, from_PS;
  logic       exec_en, halted, step_ack, stack_err;

  typedef struct packed {
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic [3:0] nib;
    logic       call;
    logic       ret;
    logic       halt_req;
    logic       step_req;
  } ctl_t;

  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic [7:0] pm;
    logic       en;
    logic       hlt;
    logic       ack;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       exp_err  = 1'b0;
  logic [7:0] p;
  logic [7:0] ret_exp [4];
  ctl_t       c;

  program_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .jmp       (jmp),
    .jmp_nz    (jmp_nz),
    .ir_nibble (ir_nibble),
    .dont_jmp  (dont_jmp),
    .call      (call),
    .ret       (ret),
    .halt_req  (halt_req),
    .step_req  (step_req),
    .pm_addr   (pm_addr),
    .pc        (pc),
    .exec_en   (exec_en),
    .halted    (halted),
    .step_ack  (step_ack),
    .stack_err (stack_err),
    .from_PS   (from_PS)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: compares the cycle driven just after the last posedge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.tag, ".pm_addr"}, pm_addr, mon_e.pm);
      check({mon_e.tag, ".pc"}, pc, mon_e.pc);
      check({mon_e.tag, ".from_PS"}, from_PS, mon_e.pc);
      check({mon_e.tag, ".exec_en"}, 8'(exec_en), 8'(mon_e.en));
      check({mon_e.tag, ".halted"}, 8'(halted), 8'(mon_e.hlt));
      check({mon_e.tag, ".step_ack"}, 8'(step_ack), 8'(mon_e.ack));
      check({mon_e.tag, ".stack_err"}, 8'(stack_err), 8'(mon_e.err));
    end
  end

  function automatic ctl_t c_idle();
    return '0;
  endfunction

  function automatic ctl_t c_jmp(input logic [3:0] n);
    ctl_t r = '0;
    r.jmp = 1'b1;
    r.nib = n;
    return r;
  endfunction

  function automatic ctl_t c_jnz(input logic [3:0] n, input logic dz);
    ctl_t r = '0;
    r.jmp_nz   = 1'b1;
    r.dont_jmp = dz;
    r.nib      = n;
    return r;
  endfunction

  function automatic ctl_t c_call(input logic [3:0] n);
    ctl_t r = '0;
    r.call = 1'b1;
    r.nib  = n;
    return r;
  endfunction

  function automatic ctl_t c_ret();
    ctl_t r = '0;
    r.ret = 1'b1;
    return r;
  endfunction

  function automatic ctl_t c_halt(input logic stp);
    ctl_t r = '0;
    r.halt_req = 1'b1;
    r.step_req = stp;
    return r;
  endfunction

  task automatic drive(input ctl_t k);
    jmp       = k.jmp;
    jmp_nz    = k.jmp_nz;
    dont_jmp  = k.dont_jmp;
    ir_nibble = k.nib;
    call      = k.call;
    ret       = k.ret;
    halt_req  = k.halt_req;
    step_req  = k.step_req;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] e_pc, input logic [7:0] e_pm,
                          input logic e_en, input logic e_hlt, input logic e_ack);
    exp_t e;
    e.tag = tag;
    e.pc  = e_pc;
    e.pm  = e_pm;
    e.en  = e_en;
    e.hlt = e_hlt;
    e.ack = e_ack;
    e.err = exp_err;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input string tag, input ctl_t k, input logic [7:0] e_pc, input logic [7:0] e_pm,
                     input logic e_en, input logic e_hlt, input logic e_ack);
    drive(k);
    push_exp(tag, e_pc, e_pm, e_en, e_hlt, e_ack);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input ctl_t k, input logic [7:0] e_pc, input logic [7:0] e_pm);
    cyc(tag, k, e_pc, e_pm, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(c_idle());
    @(posedge clk);
    #1;

    // Reset and release: 00,01,02,03
    cyc("rst0", c_idle(), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("rst1", c_idle(), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc("rel", c_idle(), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run("cnt1", c_idle(), 8'h00, 8'h01);
    run("cnt2", c_idle(), 8'h01, 8'h02);

    // Jumps and pc wrap
    run("jmpA", c_jmp(4'hA), 8'h02, 8'hA0);
    run("jnz_dz", c_jnz(4'h5, 1'b1), 8'hA0, 8'hA1);
    run("jnz_tk", c_jnz(4'hF, 1'b0), 8'hA1, 8'hF0);
    for (int i = 0; i < 16; i++) begin
      p = 8'(240 + i);
      run($sformatf("wrap%0d", i), c_idle(), p, 8'(p + 8'd1));
    end

    // Halt at pc=05, single step, resume
    for (int i = 0; i < 5; i++) begin
      p = 8'(i);
      run($sformatf("pre%0d", i), c_idle(), p, 8'(p + 8'd1));
    end
    run("h.req", c_halt(1'b0), 8'h05, 8'h06);
    c = c_halt(1'b0);
    c.jmp = 1'b1;
    c.nib = 4'h9;
    cyc("h.jmp_ign", c, 8'h06, 8'h06, 1'b0, 1'b1, 1'b0);
    cyc("h.step_req", c_halt(1'b1), 8'h06, 8'h06, 1'b0, 1'b1, 1'b0);
    cyc("h.step", c_halt(1'b0), 8'h06, 8'h07, 1'b1, 1'b0, 1'b1);
    cyc("h.held", c_halt(1'b0), 8'h07, 8'h07, 1'b0, 1'b1, 1'b0);
    cyc("h.drop", c_idle(), 8'h07, 8'h07, 1'b0, 1'b1, 1'b0);
    c = c_idle();
    c.step_req = 1'b1;
    run("r.step_ign", c, 8'h07, 8'h08);
    run("r.cnt", c_idle(), 8'h08, 8'h09);
    run("h2.req", c_halt(1'b0), 8'h09, 8'h0A);
    cyc("h2.held", c_halt(1'b0), 8'h0A, 8'h0A, 1'b0, 1'b1, 1'b0);
    cyc("h2.step_req", c_halt(1'b1), 8'h0A, 8'h0A, 1'b0, 1'b1, 1'b0);
    cyc("h2.step_drop", c_idle(), 8'h0A, 8'h0B, 1'b1, 1'b0, 1'b1);
    run("h2.run", c_idle(), 8'h0B, 8'h0C);
    run("h2.cnt", c_idle(), 8'h0C, 8'h0D);

    // Simple call/return: call at 10 (pc=11) to page 3, return to 11
    run("s4.j1", c_jmp(4'h1), 8'h0D, 8'h10);
    run("s4.n", c_idle(), 8'h10, 8'h11);
    run("s4.call", c_call(4'h3), 8'h11, RAS ? 8'h30 : 8'h12);
    run("s4.ret", c_ret(), RAS ? 8'h30 : 8'h12, RAS ? 8'h11 : 8'h13);
    run("s4.j4", c_jmp(4'h4), RAS ? 8'h11 : 8'h13, 8'h40);

    // Priority: jump suppresses call; underflow; call+ret acts as call
    c = c_jmp(4'h5);
    c.call = 1'b1;
    c.ret  = 1'b1;
    run("s5.jcall", c, 8'h40, 8'h50);
    run("s5.ret_empty", c_ret(), 8'h50, 8'h51);
    exp_err = RAS;
    c = c_call(4'h2);
    c.ret = 1'b1;
    run("s5.callret", c, 8'h51, RAS ? 8'h20 : 8'h52);
    run("s5.j3", c_jmp(4'h3), RAS ? 8'h20 : 8'h52, 8'h30);
    run("s5.ret", c_ret(), 8'h30, RAS ? 8'h51 : 8'h31);
    run("s5.j0", c_jmp(4'h0), RAS ? 8'h51 : 8'h31, 8'h00);

    // Async reset while in the single-step cycle
    run("s6.req", c_halt(1'b0), 8'h00, 8'h01);
    cyc("s6.step_req", c_halt(1'b1), 8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    drive(c_halt(1'b0));
    push_exp("s6.step", 8'h01, 8'h02, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.pc", pc, 8'h00);
    check("arst.from_PS", from_PS, 8'h00);
    check("arst.pm_addr", pm_addr, 8'h00);
    check("arst.halted", 8'(halted), 8'h00);
    check("arst.step_ack", 8'(step_ack), 8'h00);
    check("arst.exec_en", 8'(exec_en), 8'h00);
    check("arst.stack_err", 8'(stack_err), 8'h00);
    exp_err = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst2", c_halt(1'b0), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cyc("rel2", c_idle(), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Five nested calls from 70,80,90,A0,B0: the 70 entry is overwritten
    run("s7.j5", c_jmp(4'h5), 8'h00, 8'h50);
    run("s7.j7", c_jmp(4'h7), 8'h50, 8'h70);
    for (int i = 0; i < 5; i++) begin
      p = 8'(8'h70 + 8'(i * 16));
      run($sformatf("s7.call%0d", i), c_call(4'h1), p, RAS ? 8'h10 : 8'(p + 8'd1));
      if (i == 4) begin
        exp_err = RAS;
      end
      run($sformatf("s7.rsync%0d", i), c_jmp(4'(8 + i)),
          RAS ? 8'h10 : 8'(p + 8'd1), 8'(p + 8'h10));
    end
    ret_exp[0] = 8'hB0;
    ret_exp[1] = 8'hA0;
    ret_exp[2] = 8'h90;
    ret_exp[3] = 8'h80;
    for (int k = 0; k < 4; k++) begin
      run($sformatf("s7.ret%0d", k), c_ret(), 8'hC0, RAS ? ret_exp[k] : 8'hC1);
      run($sformatf("s7.back%0d", k), c_jmp(4'hC), RAS ? ret_exp[k] : 8'hC1, 8'hC0);
    end
    run("s7.ret_empty", c_ret(), 8'hC0, 8'hC1);
    run("s7.end", c_idle(), 8'hC1, 8'hC2);

    if (sb_q.size() != 0) begin
      @(negedge clk);
      #1;
    end
    check("drain", 8'(sb_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
